alu32_iterdiv: RTL and testbench

- Execution-stage datapath that sits directly downstream of the multicycle control unit.
- Consumes alu_op, start_div, alu_operand_a and alu_operand_b, and returns the ALU result plus the div_ready flag the control unit waits on.
- Single-cycle operations are purely combinational.
- DIV/DIVU/REM/REMU run on an iterative radix-2 restoring divider (1 quotient bit per cycle) with a start/ready handshake.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/div_core_32.sv | 102 ++++++++++
 rtl/alu32_iterdiv.sv | 49 ++++
 tb/tb_alu32_iterdiv.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, widths and divider state encoding shared by the ALU and its divider.
package alu_pkg;
    localparam int XLEN      = 32;
    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = $clog2(DIV_ITERS);

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_AND  = 5'b00100;
    localparam logic [4:0] ALU_OR   = 5'b00101;
    localparam logic [4:0] ALU_XOR  = 5'b00110;
    localparam logic [4:0] ALU_SLL  = 5'b00111;
    localparam logic [4:0] ALU_SRL  = 5'b01000;
    localparam logic [4:0] ALU_SRA  = 5'b01001;
    localparam logic [4:0] ALU_SLT  = 5'b01010;
    localparam logic [4:0] ALU_SLTU = 5'b01011;
    localparam logic [4:0] ALU_DIV  = 5'b01100;
    localparam logic [4:0] ALU_DIVU = 5'b01101;
    localparam logic [4:0] ALU_REM  = 5'b01110;
    localparam logic [4:0] ALU_REMU = 5'b01111;

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} div_state_e;

    function automatic logic is_div_op(input logic [4:0] op);
        return op == ALU_DIV || op == ALU_DIVU || op == ALU_REM || op == ALU_REMU;
    endfunction
endpackage

// File: rtl/div_core_32.sv
// div_core_32: radix-2 restoring divider, one quotient bit per cycle, RISC-V M semantics.
module div_core_32
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] div_result,
    output logic            busy,
    output logic            ready
);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, div_result_q, div_result_d;
    logic [4:0] op_q, op_d;
    logic neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic sgn;
    logic [XLEN:0] rem_sh, diff;
    logic [XLEN-1:0] q_fix, r_fix;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            dvs_q        <= '0;
            op_q         <= '0;
            neg_a_q      <= 1'b0;
            neg_b_q      <= 1'b0;
            div_result_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            dvs_q        <= dvs_d;
            op_q         <= op_d;
            neg_a_q      <= neg_a_d;
            neg_b_q      <= neg_b_d;
            div_result_q <= div_result_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        dvs_d        = dvs_q;
        op_d         = op_q;
        neg_a_d      = neg_a_q;
        neg_b_d      = neg_b_q;
        div_result_d = div_result_q;
        sgn          = op == ALU_DIV || op == ALU_REM;
        rem_sh       = {rem_q, quo_q[XLEN-1]};
        diff         = rem_sh - {1'b0, dvs_q};
        q_fix        = (op_q == ALU_DIV && (neg_a_q ^ neg_b_q)) ? -quo_q : quo_q;
        r_fix        = (op_q == ALU_REM && neg_a_q) ? -rem_q : rem_q;
        case (state_q)
            IDLE: if (start && is_div_op(op)) begin
                op_d    = op;
                neg_a_d = sgn & a[XLEN-1];
                neg_b_d = sgn & b[XLEN-1];
                quo_d   = (sgn && a[XLEN-1]) ? -a : a;
                dvs_d   = (sgn && b[XLEN-1]) ? -b : b;
                rem_d   = '0;
                cnt_d   = CNT_W'(DIV_ITERS - 1);
                if (b == '0) begin
                    div_result_d = (op == ALU_DIV || op == ALU_DIVU) ? '1 : a;
                    state_d      = DONE;
                end else if (sgn && a == MIN_INT && b == '1) begin
                    div_result_d = (op == ALU_DIV) ? MIN_INT : '0;
                    state_d      = DONE;
                end else begin
                    state_d = ITER;
                end
            end
            ITER: begin
                // a borrow out of the trial subtraction means the divisor did not fit
                rem_d   = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
                quo_d   = {quo_q[XLEN-2:0], ~diff[XLEN]};
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == '0) ? FIX : ITER;
            end
            FIX: begin
                div_result_d = (op_q == ALU_DIV || op_q == ALU_DIVU) ? q_fix : r_fix;
                state_d      = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign div_result = div_result_q;
    assign busy       = state_q == ITER || state_q == FIX;
    assign ready      = state_q == DONE;
endmodule

// File: rtl/alu32_iterdiv.sv
// alu32_iterdiv: combinational 32-bit ALU with an iterative divider behind the divide opcodes.
module alu32_iterdiv
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      alu_op,
    input  logic            start_div,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            div_busy,
    output logic            div_ready
);
    logic [XLEN-1:0] div_result;

    div_core_32 u_div (
        .clk        (clk),
        .reset      (reset),
        .start      (start_div),
        .op         (alu_op),
        .a          (operand_a),
        .b          (operand_b),
        .div_result (div_result),
        .busy       (div_busy),
        .ready      (div_ready)
    );

    always_comb begin
        result = '0;
        case (alu_op)
            ALU_ADD:  result = operand_a + operand_b;
            ALU_SUB:  result = operand_a - operand_b;
            ALU_AND:  result = operand_a & operand_b;
            ALU_OR:   result = operand_a | operand_b;
            ALU_XOR:  result = operand_a ^ operand_b;
            ALU_SLL:  result = operand_a << operand_b[4:0];
            ALU_SRL:  result = operand_a >> operand_b[4:0];
            ALU_SRA:  result = $unsigned($signed(operand_a) >>> operand_b[4:0]);
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, operand_a < operand_b};
            ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: result = div_result;
            default:  result = '0;
        endcase
    end

    assign zero = result == '0;
endmodule

// File: tb/tb_alu32_iterdiv.sv
// tb_alu32_iterdiv: directed ALU vectors plus scoreboarded divide checks against a reference model.
module tb_alu32_iterdiv;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  alu_op = ALU_ADD;
    logic        start_div = 1'b0;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic [31:0] result;
    logic        zero, div_busy, div_ready;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    typedef struct {logic [4:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] exp;} vec_t;
    vec_t vecs[11] = '{
        '{ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000},
        '{ALU_SUB,  32'h00000005, 32'h00000005, 32'h00000000},
        '{ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000},
        '{ALU_OR,   32'h00000F00, 32'h000000F0, 32'h00000FF0},
        '{ALU_XOR,  32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555},
        '{ALU_SLL,  32'h00000001, 32'h0000003F, 32'h80000000},
        '{ALU_SRL,  32'h80000000, 32'h00000004, 32'h08000000},
        '{ALU_SRA,  32'h80000000, 32'h00000004, 32'hF8000000},
        '{ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001},
        '{ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000},
        '{5'b10101, 32'h12345678, 32'h9ABCDEF0, 32'h00000000}
    };

    alu32_iterdiv dut (
        .clk       (clk),
        .reset     (reset),
        .alu_op    (alu_op),
        .start_div (start_div),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .result    (result),
        .zero      (zero),
        .div_busy  (div_busy),
        .div_ready (div_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 0) return (op == ALU_DIV || op == ALU_DIVU) ? 32'hFFFFFFFF : a;
        if ((op == ALU_DIV || op == ALU_REM) && a == 32'h80000000 && b == 32'hFFFFFFFF)
            return (op == ALU_DIV) ? 32'h80000000 : 32'h0;
        case (op)
            ALU_DIV:  return sa / sb;
            ALU_REM:  return sa % sb;
            ALU_DIVU: return a / b;
            default:  return a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 0) return 0;
        if ((op == ALU_DIV || op == ALU_REM) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 0;
        return 33;
    endfunction

    always @(negedge clk) begin
        if (!reset && div_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got result %h with no divide pending", result);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("div_result", result, e);
                chk("div_zero", {31'b0, zero}, {31'b0, e == 0});
            end
        end
    end

    task automatic wait_ready(output int n);
        n = 0;
        @(negedge clk);
        while (!div_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_div(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        exp_q.push_back(ref_div(op, a, b));
        alu_op = op;
        operand_a = a;
        operand_b = b;
        start_div = 1'b1;
        @(posedge clk);
        #1 start_div = 1'b0;
        wait_ready(n);
        chk("div_latency", n, ref_lat(op, a, b));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        alu_op = ALU_DIV;
        #2;
        chk("reset_busy", {31'b0, div_busy}, 0);
        chk("reset_ready", {31'b0, div_ready}, 0);
        chk("reset_div_result", result, 0);
        chk("reset_zero", {31'b0, zero}, 1);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        foreach (vecs[i]) begin
            alu_op = vecs[i].op;
            operand_a = vecs[i].a;
            operand_b = vecs[i].b;
            #1;
            chk($sformatf("comb_op%0d", i), result, vecs[i].exp);
            chk($sformatf("comb_zero%0d", i), {31'b0, zero}, {31'b0, vecs[i].exp == 0});
        end
        @(posedge clk);
        #1;

        // start with a non-divide opcode must be ignored
        alu_op = ALU_ADD;
        start_div = 1'b1;
        @(posedge clk);
        #1 start_div = 1'b0;
        chk("nondiv_start_busy", {31'b0, div_busy}, 0);
        @(negedge clk);
        chk("nondiv_start_ready", {31'b0, div_ready}, 0);
        @(posedge clk);
        #1;

        // DIV -7/2 with cycle-exact busy/ready profile
        exp_q.push_back(32'hFFFFFFFD);
        alu_op = ALU_DIV;
        operand_a = 32'hFFFFFFF9;
        operand_b = 32'h00000002;
        start_div = 1'b1;
        @(posedge clk);
        #1 start_div = 1'b0;
        for (int k = 0; k <= 34; k++) begin
            @(negedge clk);
            chk($sformatf("busy_k%0d", k), {31'b0, div_busy}, {31'b0, k <= 32});
            chk($sformatf("ready_k%0d", k), {31'b0, div_ready}, {31'b0, k == 33});
        end
        @(posedge clk);
        #1;

        run_div(ALU_REM,  32'hFFFFFFF9, 32'h00000002);
        run_div(ALU_DIVU, 32'd100,      32'd0);
        run_div(ALU_REMU, 32'd100,      32'd0);
        run_div(ALU_DIV,  32'h80000000, 32'hFFFFFFFF);
        run_div(ALU_REM,  32'h80000000, 32'hFFFFFFFF);
        run_div(ALU_DIV,  32'd20,       32'd0);
        run_div(ALU_REM,  32'hFFFFFFEC, 32'd0);

        // restart attempt during ITER is ignored
        exp_q.push_back(32'd142);
        alu_op = ALU_DIVU;
        operand_a = 32'd1000;
        operand_b = 32'd7;
        start_div = 1'b1;
        @(posedge clk);
        #1 start_div = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        operand_a = 32'd50;
        operand_b = 32'd5;
        start_div = 1'b1;
        @(posedge clk);
        #1 start_div = 1'b0;
        wait_ready(n);
        chk("restart_latency", n, 28);
        @(posedge clk);
        #1;

        // reset mid-divide
        operand_a = 32'd1000;
        operand_b = 32'd7;
        start_div = 1'b1;
        @(posedge clk);
        #1 start_div = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("midreset_busy", {31'b0, div_busy}, 0);
        chk("midreset_result", result, 0);
        chk("midreset_zero", {31'b0, zero}, 1);
        @(posedge clk);
        #1 reset = 1'b0;
        wait_ready(n);
        chk("midreset_no_ready", n, 60);
        @(posedge clk);
        #1;

        for (int i = 0; i < 1000; i++) begin
            logic [4:0] op;
            logic [31:0] a, b;
            op = ALU_DIV + 5'($urandom_range(3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(7))
                0: b = 0;
                1: b = $urandom_range(16);
                2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                3: a = $urandom_range(1000);
                4: b = 32'hFFFFFFFF - $urandom_range(3);
                default: ;
            endcase
            run_div(op, a, b);
        end

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
